// File: rtl/dmem_responder_if.sv
// CPU data-memory bus between the core's ME stage and dmem_responder, plus the
// peripheral-side req/ack port that the responder drives for the I/O window.
interface dmem_responder_if;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [2:0]  dm_ctrl;
  logic [31:0] Data_out;
  logic        MIO_ready;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic        io_ack;
  logic [31:0] io_rdata;
  logic        bus_err;
  logic        misalign_err;

  // Responder view.
  modport slave (
    input  CPU_MIO, mem_w, Addr_in, Data_in, dm_ctrl, io_ack, io_rdata,
    output Data_out, MIO_ready, io_req, io_we, io_addr, io_wdata, io_be,
           bus_err, misalign_err
  );

  // CPU / peripheral view.
  modport master (
    output CPU_MIO, mem_w, Addr_in, Data_in, dm_ctrl, io_ack, io_rdata,
    input  Data_out, MIO_ready, io_req, io_we, io_addr, io_wdata, io_be,
           bus_err, misalign_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM with extended loads, and an I/O window
// (Addr_in[31:28] == 4'hF) forwarded through a req/ack FSM with timeout.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses are
// suppressed and flagged on misalign_err instead of truncating low bits).
//
// state  | meaning
// IDLE   | ready; RAM accesses complete at once, I/O accesses are latched
// WAIT   | io_req held, counting cycles until io_ack or timeout
// DONE   | captured word returned, MIO_ready high, back to IDLE next
module dmem_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int IO_TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(IO_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          io_req_q;
  logic          io_we_q;
  logic [31:0]   io_addr_q;
  logic [31:0]   io_wdata_q;
  logic [3:0]    io_be_q;
  logic [31:0]   cap_data;
  logic [2:0]    cap_ctrl;
  logic          bus_err_q;
  logic          misalign_err_q;

  logic [31:0]   mem [RAM_WORDS];

  logic          is_io;
  logic          is_half;
  logic          is_byte;
  logic          misal;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_rd;
  logic          accept;
  logic          ram_wr;

  // Pick the addressed lane out of a word and extend it per dm_ctrl.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  a,
                                           input logic [2:0]  c);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = w[{a, 3'b000} +: 8];
    case (c)
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {16'h0000, h};
      3'b011:  return {{24{b[7]}}, b};
      3'b100:  return {24'h000000, b};
      default: return w;
    endcase
  endfunction

  // Access decode: region, size, byte enables and lane-replicated write data.
  always_comb begin
    is_io   = (bus.Addr_in[31:28] == 4'hF);
    is_half = (bus.dm_ctrl == 3'b001) || (bus.dm_ctrl == 3'b010);
    is_byte = (bus.dm_ctrl == 3'b011) || (bus.dm_ctrl == 3'b100);
    be      = 4'b1111;
    wdata   = bus.Data_in;
    if (is_half) begin
      be    = 4'b0011 << {bus.Addr_in[1], 1'b0};
      wdata = {2{bus.Data_in[15:0]}};
    end else if (is_byte) begin
      be    = 4'b0001 << bus.Addr_in[1:0];
      wdata = {4{bus.Data_in[7:0]}};
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal = bus.CPU_MIO &&
                 ((is_half && bus.Addr_in[0]) ||
                  (!is_half && !is_byte && (bus.Addr_in[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign ram_idx = bus.Addr_in[AW+1:2];
  assign ram_rd  = mem[ram_idx];
  assign accept  = (state == S_IDLE) && bus.CPU_MIO && is_io && !misal;
  assign ram_wr  = (state == S_IDLE) && bus.CPU_MIO && bus.mem_w && !is_io && !misal;

  // RAM store: only the enabled lanes are written; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_wr && be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // I/O sequencing FSM with registered peripheral-side outputs and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      io_req_q       <= 1'b0;
      io_we_q        <= 1'b0;
      io_addr_q      <= '0;
      io_wdata_q     <= '0;
      io_be_q        <= '0;
      cap_data       <= '0;
      cap_ctrl       <= '0;
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.CPU_MIO) misalign_err_q <= misal;
          if (accept) begin
            io_addr_q  <= bus.Addr_in;
            io_we_q    <= bus.mem_w;
            io_be_q    <= be;
            io_wdata_q <= wdata;
            cap_ctrl   <= bus.dm_ctrl;
            io_req_q   <= 1'b1;
            wait_cnt   <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Ack wins over timeout when both land on the last wait cycle.
          if (bus.io_ack) begin
            cap_data <= bus.io_rdata;
            io_req_q <= 1'b0;
            state    <= S_DONE;
          end else if (wait_cnt == CW'(IO_TIMEOUT - 1)) begin
            cap_data  <= 32'hDEAD_BEEF;
            bus_err_q <= 1'b1;
            io_req_q  <= 1'b0;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // CPU-side return path: combinational load data and ready.
  always_comb begin
    bus.Data_out  = 32'h0;
    bus.MIO_ready = 1'b1;
    case (state)
      S_DONE: bus.Data_out = load_ext(cap_data, io_addr_q[1:0], cap_ctrl);
      S_WAIT: bus.MIO_ready = 1'b0;
      default: begin
        if (bus.CPU_MIO && !misal) begin
          if (is_io) bus.MIO_ready = 1'b0;
          else       bus.Data_out  = load_ext(ram_rd, bus.Addr_in[1:0], bus.dm_ctrl);
        end
      end
    endcase
  end

  assign bus.io_req       = io_req_q;
  assign bus.io_we        = io_we_q;
  assign bus.io_addr      = io_addr_q;
  assign bus.io_wdata     = io_wdata_q;
  assign bus.io_be        = io_be_q;
  assign bus.bus_err      = bus_err_q;
  assign bus.misalign_err = misalign_err_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the CPU data-memory bus. It accepts the core's ME-stage accesses (address, write data, `mem_w`, `dm_ctrl`, `CPU_MIO` strobe) and returns load data and `MIO_ready`. It contains a byte-lane data RAM with load sign/zero extension, and forwards accesses in the I/O window to an external peripheral port through a req/ack FSM with timeout.

## Interface
- `RAM_WORDS`, default 1024: number of 32-bit RAM words; RAM index is `Addr_in[log2(RAM_WORDS)+1:2]`.
- `IO_TIMEOUT`, default 16: maximum number of WAIT cycles before an I/O access is aborted.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `CPU_MIO` in 1: access strobe, valid this cycle.
- `mem_w` in 1: 1 = store, 0 = load.
- `Addr_in` in 32: byte address.
- `Data_in` in 32: store data, right-aligned.
- `dm_ctrl` in 3: access size. 000 = word; 001 = half, signed; 010 = half, unsigned; 011 = byte, signed; 100 = byte, unsigned; others are treated as word.
- `Data_out` out 32: load data, extended.
- `MIO_ready` out 1: the access completes this cycle.
- `io_req` out 1: peripheral request, held until ack or timeout.
- `io_we` out 1: peripheral write.
- `io_addr` out 32: latched address.
- `io_wdata` out 32: lane-positioned write data.
- `io_be` out 4: byte enables.
- `io_ack` in 1: peripheral done; `io_rdata` is valid in the same cycle.
- `io_rdata` in 32: peripheral read word.
- `bus_err` out 1: one-cycle pulse on I/O timeout.
- `misalign_err` out 1: misaligned access flag (see Configuration).

## Operation
- **Region decode.** `Addr_in[31:28]==4'hF` selects the I/O window. Every other address selects RAM and wraps modulo the RAM size.
- **Byte lanes (little-endian).**
  - Word: `be=1111`.
  - Half: `be=0011<<(2*Addr_in[1])`; write data is `{2{Data_in[15:0]}}`.
  - Byte: `be=0001<<Addr_in[1:0]`; write data is `{4{Data_in[7:0]}}`.
- **Load extension.** The selected lane is taken from the read word, then sign- or zero-extended per `dm_ctrl`.
- **RAM path.**
  - Read is combinational: `Data_out` is valid in the same cycle `CPU_MIO` is high.
  - A store writes the enabled lanes at the rising edge.
  - `MIO_ready=1` combinationally.
- **I/O FSM, IDLE.** On `CPU_MIO` with an I/O address:
  - latch `io_addr`, `io_we`, `io_be`, `io_wdata`;
  - set `io_req=1`;
  - clear the wait counter;
  - go to WAIT.
  - `MIO_ready=0` in this cycle.
- **I/O FSM, WAIT.** `io_req=1`; the counter increments each cycle.
  - `io_ack=1`: capture `io_rdata`; go to DONE.
  - Else if counter `== IO_TIMEOUT-1`: capture `32'hDEAD_BEEF`, set the error flag, go to DONE.
  - `io_ack` takes priority over timeout in the same cycle.
- **I/O FSM, DONE.**
  - `io_req=0`.
  - `MIO_ready=1`.
  - `Data_out` = extended captured word.
  - `bus_err=1` if the access timed out.
  - Always returns to IDLE.
  - The CPU treats the request as consumed at this edge. The IDLE cycle that follows may accept a new access.
- **Idle outputs.** With `CPU_MIO=0`: `Data_out=0`; `MIO_ready=1` in IDLE, 0 in WAIT.
- **CPU obligation.** The CPU holds its request stable from IDLE acceptance through DONE. The responder ignores input changes during WAIT.

## Timing
- RAM load: 0-cycle latency. RAM store: visible to a load in the next cycle.
- I/O access latency: 1 (IDLE→WAIT) + k WAIT cycles + 1 DONE cycle, with 1 ≤ k ≤ `IO_TIMEOUT`.
- Reset values: state IDLE. `io_req`, `io_we` = 0. `io_addr`, `io_wdata`, `io_be`, captured data = 0. `bus_err`, `misalign_err` = 0. Wait counter = 0.
- Reset mid-WAIT: `io_req` drops asynchronously and no DONE is issued. RAM contents are not reset.
- Registered outputs: `io_*`, `bus_err`, `misalign_err`. All others are combinational.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- **Defined.** A half access with `Addr_in[0]=1`, or a word access with `Addr_in[1:0]!=0`, is treated as misaligned:
  - the store is suppressed (RAM and I/O);
  - the load returns 0;
  - `MIO_ready=1`;
  - `misalign_err` is set at the next edge and held until the next aligned `CPU_MIO` access.
  - An I/O request is not issued.
- **Undefined.** Low address bits beyond the lane selection are ignored: a word access uses `Addr_in[31:2]`, and a half access uses `Addr_in[1]`. `misalign_err` is tied to 0.

## Test plan
- **Stores and extended loads.** SW `0x80FF7F01` @0x20, then:
  - LB @0x22 → `0xFFFFFFFF`;
  - LBU @0x22 → `0x000000FF`;
  - LH @0x22 → `0xFFFF80FF`;
  - LHU @0x22 → `0x000080FF`;
  - LW @0x20 → `0x80FF7F01`.
- **Byte store merge.** SB `0x123456AB` @0x21, then LW @0x20 → `0x80FFAB01`; the other bytes are untouched.
- **I/O store.** SB `0x55` @`0xF0000006`:
  - `io_be=0100`, `io_wdata=0x55555555`, `io_we=1`;
  - `io_ack` arrives on the 3rd WAIT cycle;
  - `io_req` is high for 3 cycles and `MIO_ready` pulses once, in DONE.
- **I/O timeout.** LW @`0xF0000000`, no ack, `IO_TIMEOUT=16`:
  - 16 WAIT cycles, then DONE with `Data_out=0xDEADBEEF` and a 1-cycle `bus_err`.
- **Reset mid-access.** Assert `rst=0` on the 2nd WAIT cycle:
  - `io_req=0` immediately and the state is IDLE;
  - after release, an idle cycle shows `MIO_ready=1`;
  - RAM data written before reset still reads back.
- **Misaligned load.** LW @0x22:
  - with the macro: `Data_out=0` and `misalign_err=1`; a following SW @0x23 leaves RAM unchanged;
  - without the macro: returns the word at 0x20.
